// File: rtl/ccp_pkg.sv
// Shared coherence-channel widths, message encodings and helpers.
// Imported by the channel arbiter and its per-source queues.
package ccp_pkg;

  localparam int MSG_WIDTH  = 3;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 16;
  localparam int OWNER_BITS = 4;

  typedef enum logic [MSG_WIDTH-1:0] {
    MSG_GETS    = 3'd0,
    MSG_GETM    = 3'd1,
    MSG_PUTS    = 3'd2,
    MSG_PUTM    = 3'd3,
    MSG_INV_ACK = 3'd4,
    MSG_WB      = 3'd5
  } msg_type_e;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccp_msg_fifo.sv
// Per-source message queue; a full queue refuses input
// even in a cycle where it is also popped.
module ccp_msg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  import ccp_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ccp_chan_arbiter.sv
// Merges per-cache request queues onto one L2 channel through
// a round-robin or fixed-priority arbiter and one output register.
module ccp_chan_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = 0,
  parameter int CNT_WIDTH  = 9,
  parameter int MSG_WIDTH  = ccp_pkg::MSG_WIDTH,
  parameter int DATA_WIDTH = ccp_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = ccp_pkg::TAG_WIDTH,
  localparam int SRC_W     = ccp_pkg::src_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            in_valid,
  output logic [NUM_SRC-1:0]            in_ready,
  input  logic [NUM_SRC*MSG_WIDTH-1:0]  in_type,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SRC*TAG_WIDTH-1:0]  in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MSG_WIDTH-1:0]          out_type,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic [SRC_W-1:0]              out_source,
  output logic [CNT_WIDTH-1:0]          dbg_cycles
);
  import ccp_pkg::*;

  localparam int PW = MSG_WIDTH + DATA_WIDTH + TAG_WIDTH;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [PW-1:0]      head [NUM_SRC];
  logic [SRC_W-1:0]   last_grant;
  logic [SRC_W-1:0]   grant;
  logic               found;
  logic               load;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_q
    assign push[i] = in_valid[i] && !full[i];
    assign pop[i]  = load && (grant == SRC_W'(i));

    ccp_msg_fifo #(
      .WIDTH (PW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   ({in_type[i*MSG_WIDTH +: MSG_WIDTH],
               in_data[i*DATA_WIDTH +: DATA_WIDTH],
               in_tag[i*TAG_WIDTH +: TAG_WIDTH]}),
      .pop   (pop[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign in_ready = ~full;

  // Search order starts just past the last winner in round-robin mode.
  always_comb begin : p_grant
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ARB_MODE == 1) idx = i;
      else idx = (int'(last_grant) + 1 + i) % NUM_SRC;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = SRC_W'(idx);
      end
    end
  end

  assign load = (!out_valid || out_ready) && found;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_type   <= '0;
      out_data   <= '0;
      out_tag    <= '0;
      out_source <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
    end else if (load) begin
      out_valid  <= 1'b1;
      {out_type, out_data, out_tag} <= head[grant];
      out_source <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_cycles <= '0;
    else     dbg_cycles <= dbg_cycles + 1'b1;
  end

endmodule

// File: tb/tb_ccp_chan_arbiter.sv
// Scoreboard bench for ccp_chan_arbiter: round-robin and
// fixed-priority instances driven with directed vectors.
module tb_ccp_chan_arbiter;

  localparam int N  = 4;
  localparam int MW = 3;
  localparam int DW = 32;
  localparam int TW = 16;

  typedef struct packed {
    logic [1:0]    src;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    a_in_valid, a_in_ready;
  logic [N*MW-1:0] a_in_type;
  logic [N*DW-1:0] a_in_data;
  logic [N*TW-1:0] a_in_tag;
  logic            a_out_valid, a_out_ready;
  logic [MW-1:0]   a_out_type;
  logic [DW-1:0]   a_out_data;
  logic [TW-1:0]   a_out_tag;
  logic [1:0]      a_out_source;
  logic [8:0]      a_dbg;

  logic [N-1:0]    b_in_valid, b_in_ready;
  logic [N*MW-1:0] b_in_type;
  logic [N*DW-1:0] b_in_data;
  logic [N*TW-1:0] b_in_tag;
  logic            b_out_valid, b_out_ready;
  logic [MW-1:0]   b_out_type;
  logic [DW-1:0]   b_out_data;
  logic [TW-1:0]   b_out_tag;
  logic [1:0]      b_out_source;
  logic [8:0]      b_dbg;

  int tests  = 0;
  int failed = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic        ha_v = 1'b0, hb_v = 1'b0;
  logic [63:0] ha_p, hb_p;

  always #5 clk = ~clk;

  ccp_chan_arbiter #(.ARB_MODE(0)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_type    (a_in_type),
    .in_data    (a_in_data),
    .in_tag     (a_in_tag),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_type   (a_out_type),
    .out_data   (a_out_data),
    .out_tag    (a_out_tag),
    .out_source (a_out_source),
    .dbg_cycles (a_dbg)
  );

  ccp_chan_arbiter #(.ARB_MODE(1)) u_fp (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_type    (b_in_type),
    .in_data    (b_in_data),
    .in_tag     (b_in_tag),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_type   (b_out_type),
    .out_data   (b_out_data),
    .out_tag    (b_out_tag),
    .out_source (b_out_source),
    .dbg_cycles (b_dbg)
  );

  function automatic logic [DW-1:0] mk_data(input logic [TW-1:0] t);
    return {16'hD00D, t};
  endfunction

  function automatic logic [MW-1:0] mk_type(input logic [TW-1:0] t);
    return t[MW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_a(input logic [N-1:0] v, input logic [N*TW-1:0] t);
    a_in_valid = v;
    a_in_tag   = t;
    for (int i = 0; i < N; i++) begin
      a_in_data[i*DW +: DW] = mk_data(t[i*TW +: TW]);
      a_in_type[i*MW +: MW] = mk_type(t[i*TW +: TW]);
    end
  endtask

  task automatic set_b(input logic [N-1:0] v, input logic [N*TW-1:0] t);
    b_in_valid = v;
    b_in_tag   = t;
    for (int i = 0; i < N; i++) begin
      b_in_data[i*DW +: DW] = mk_data(t[i*TW +: TW]);
      b_in_type[i*MW +: MW] = mk_type(t[i*TW +: TW]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain_a(input int budget);
    int n = 0;
    while (qa.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("a_drain_left", 64'(qa.size()), 64'd0);
    #1 chk("a_idle", 64'(a_out_valid), 64'd0);
  endtask

  task automatic drain_b(input int budget);
    int n = 0;
    while (qb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("b_drain_left", 64'(qb.size()), 64'd0);
    #1 chk("b_idle", 64'(b_out_valid), 64'd0);
  endtask

  // Monitor: a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      ha_v = 1'b0;
      hb_v = 1'b0;
    end else begin
      if (ha_v && a_out_valid)
        chk("a_hold", {11'd0, a_out_source, a_out_type, a_out_tag, a_out_data}, ha_p);
      ha_v = a_out_valid && !a_out_ready;
      ha_p = {11'd0, a_out_source, a_out_type, a_out_tag, a_out_data};
      if (a_out_valid && a_out_ready) begin
        tests++;
        if (qa.size() == 0) begin
          failed++;
          $display("FAIL a_extra: got tag %0h src %0d expected none", a_out_tag, a_out_source);
        end else begin
          tests--;
          ea = qa.pop_front();
          chk("a_src", 64'(a_out_source), 64'(ea.src));
          chk("a_tag", 64'(a_out_tag), 64'(ea.tag));
          chk("a_data", 64'(a_out_data), 64'(mk_data(ea.tag)));
          chk("a_type", 64'(a_out_type), 64'(mk_type(ea.tag)));
        end
      end
      if (hb_v && b_out_valid)
        chk("b_hold", {11'd0, b_out_source, b_out_type, b_out_tag, b_out_data}, hb_p);
      hb_v = b_out_valid && !b_out_ready;
      hb_p = {11'd0, b_out_source, b_out_type, b_out_tag, b_out_data};
      if (b_out_valid && b_out_ready) begin
        tests++;
        if (qb.size() == 0) begin
          failed++;
          $display("FAIL b_extra: got tag %0h src %0d expected none", b_out_tag, b_out_source);
        end else begin
          tests--;
          eb = qb.pop_front();
          chk("b_src", 64'(b_out_source), 64'(eb.src));
          chk("b_tag", 64'(b_out_tag), 64'(eb.tag));
          chk("b_data", 64'(b_out_data), 64'(mk_data(eb.tag)));
          chk("b_type", 64'(b_out_type), 64'(mk_type(eb.tag)));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    set_a('0, '0);
    set_b('0, '0);
    do_reset();

    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'hF);
    chk("rst_tag", 64'(a_out_tag), 64'd0);
    chk("rst_src", 64'(a_out_source), 64'd0);
    chk("rst_dbg", 64'(a_dbg), 64'd0);

    // Single message from source 2: visible two edges later.
    qa.push_back('{2'd2, 16'h001A});
    set_a(4'b0100, {16'h0, 16'h001A, 16'h0, 16'h0});
    step();
    set_a('0, '0);
    chk("lat1_valid", 64'(a_out_valid), 64'd0);
    step();
    chk("lat2_valid", 64'(a_out_valid), 64'd1);
    chk("lat2_src", 64'(a_out_source), 64'd2);
    chk("lat2_tag", 64'(a_out_tag), 64'h1A);
    drain_a(10);

    // Round-robin over four sources, two messages each.
    do_reset();
    a_out_ready = 1'b0;
    for (int i = 0; i < N; i++) qa.push_back('{2'(i), 16'h0A00 + 16'(i)});
    for (int i = 0; i < N; i++) qa.push_back('{2'(i), 16'h0B00 + 16'(i)});
    set_a(4'hF, {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00});
    step();
    set_a(4'hF, {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00});
    step();
    set_a('0, '0);
    a_out_ready = 1'b1;
    drain_a(20);

    // Backpressure on source 0.
    do_reset();
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qa.push_back('{2'd0, 16'h0100 + 16'(i)});
      chk("bp_ready", 64'(a_in_ready[0]), 64'd1);
      set_a(4'b0001, {48'd0, 16'h0100 + 16'(i)});
      step();
    end
    set_a('0, '0);
    chk("bp_full", 64'(a_in_ready[0]), 64'd0);
    chk("bp_head", 64'(a_out_tag), 64'h0100);
    repeat (5) step();
    chk("bp_full_hold", 64'(a_in_ready[0]), 64'd0);
    // Full queue must refuse even while it dequeues.
    a_out_ready = 1'b1;
    set_a(4'b0001, {48'd0, 16'h01FF});
    step();
    set_a('0, '0);
    drain_a(10);
    repeat (4) step();

    // Reset with messages queued and one held.
    do_reset();
    a_out_ready = 1'b0;
    set_a(4'b1110, {16'h0203, 16'h0202, 16'h0201, 16'h0});
    step();
    set_a('0, '0);
    step();
    chk("mid_held", 64'(a_out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", 64'(a_out_valid), 64'd0);
    chk("mid_in_ready", 64'(a_in_ready), 64'hF);
    chk("mid_tag", 64'(a_out_tag), 64'd0);
    a_out_ready = 1'b1;
    repeat (8) step();
    chk("mid_stale", 64'(a_out_valid), 64'd0);

    // Fixed priority: source 1 drains fully before source 3.
    do_reset();
    b_out_ready = 1'b0;
    qb.push_back('{2'd1, 16'h0301});
    qb.push_back('{2'd1, 16'h0311});
    qb.push_back('{2'd3, 16'h0303});
    qb.push_back('{2'd3, 16'h0313});
    set_b(4'b1010, {16'h0303, 16'h0, 16'h0301, 16'h0});
    step();
    set_b(4'b1010, {16'h0313, 16'h0, 16'h0311, 16'h0});
    step();
    set_b('0, '0);
    b_out_ready = 1'b1;
    drain_b(20);

    // Debug counter wrap.
    do_reset();
    chk("dbg_zero", 64'(a_dbg), 64'd0);
    repeat (511) @(posedge clk);
    #1 chk("dbg_max", 64'(a_dbg), 64'd511);
    step();
    chk("dbg_wrap", 64'(a_dbg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
